wb_write_serializer: RTL and testbench

- Merges the two retiring write-back lanes of the 2-way pipeline into the single register-file write port (RegWrite / WriteReg_WB / WriteData).
- Holds writes in a small in-order queue and drains them one per cycle.
- Provides combinational forwarding lookups so decode sees values that are queued but not yet in the register file.

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_pending_cam.sv | 32 +++
 rtl/wb_write_serializer.sv | 137 +++++++++++++
 tb/tb_wb_write_serializer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back serializer.
package wb_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned AW_DEFAULT    = 5;
  localparam int unsigned DW_DEFAULT    = 32;

  localparam logic [AW_DEFAULT-1:0] REG_ZERO = 5'd0;

  // One pending register-file write.
  typedef struct packed {
    logic [AW_DEFAULT-1:0] dest;
    logic [DW_DEFAULT-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_pending_cam.sv
// Lookup of the youngest pending write to a register among queued entries.
module wb_pending_cam
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0]      entries,
  input  logic      [DEPTH-1:0]      valid,
  input  logic      [PW-1:0]         head,
  input  logic      [AW_DEFAULT-1:0] addr,
  output logic                       hit_c,
  output logic      [DW_DEFAULT-1:0] data_c
);

  logic [PW-1:0] idx;

  // Walk from head towards tail; later (younger) matches overwrite earlier ones.
  always_comb begin
    hit_c  = 1'b0;
    data_c = '0;
    idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && (entries[idx].dest == addr) && (addr != REG_ZERO)) begin
        hit_c  = 1'b1;
        data_c = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_write_serializer.sv
// Serializes two write-back lanes into the single register-file write port,
// with forwarding lookups into the pending-write queue.
module wb_write_serializer
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          wb0_valid,
  input  logic [AW-1:0] wb0_dest,
  input  logic [DW-1:0] wb0_data,
  input  logic          wb1_valid,
  input  logic [AW-1:0] wb1_dest,
  input  logic [DW-1:0] wb1_data,
  output logic          wb_stall,
  output logic          RegWrite,
  output logic [AW-1:0] WriteReg_WB,
  output logic [DW-1:0] WriteData,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  output logic          fwd_hit_rs,
  output logic          fwd_hit_rt,
  output logic [DW-1:0] fwd_data_rs,
  output logic [DW-1:0] fwd_data_rt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Entry storage is shaped by the package struct, so widths must agree.
  if ((AW != AW_DEFAULT) || (DW != DW_DEFAULT)) begin : g_width_check
    $error("wb_write_serializer: AW/DW must match wb_pkg entry widths");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("wb_write_serializer: DEPTH must be a power of two >= 2");
  end

  wb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;

  logic [DEPTH-1:0]      valid_mask;
  logic [PW-1:0]         offset;

  logic                  take;
  logic                  elig0;
  logic                  elig1;
  logic                  push0;
  logic                  push1;
  logic                  pop;
  logic [CW-1:0]         push_cnt;
  logic [PW-1:0]         slot1;

  // Stall from registered occupancy keeps two slots free whenever lanes are accepted.
  assign wb_stall = (count > CW'(DEPTH - 2));
  assign take     = Reset && !wb_stall;

  // Enqueue filter: drop r0 writes; on equal destinations the younger lane wins.
  always_comb begin
    elig0    = wb0_valid && (wb0_dest != REG_ZERO);
    elig1    = wb1_valid && (wb1_dest != REG_ZERO);
    push1    = take && elig1;
    push0    = take && elig0 && !(elig1 && (wb0_dest == wb1_dest));
    push_cnt = CW'(push0) + CW'(push1);
    slot1    = wr_ptr + PW'(push0);
  end

  // Head drains every cycle the queue is non-empty; no back-pressure.
  assign pop = (count != '0);

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(push_cnt);
      count  <= count + push_cnt - CW'(pop);
    end
  end

  // Entry storage; contents are only meaningful under the valid mask.
  always_ff @(posedge clk) begin
    if (push0) begin
      mem[wr_ptr] <= '{dest: wb0_dest, data: wb0_data};
    end
    if (push1) begin
      mem[slot1] <= '{dest: wb1_dest, data: wb1_data};
    end
  end

  // Entries from head for count slots are live, modulo DEPTH.
  always_comb begin
    valid_mask = '0;
    offset     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset        = PW'(i) - rd_ptr;
      valid_mask[i] = ({1'b0, offset} < count);
    end
  end

  // Register-file port driven from the head entry, zeroed when idle.
  always_comb begin
    RegWrite    = pop;
    WriteReg_WB = '0;
    WriteData   = '0;
    if (pop) begin
      WriteReg_WB = mem[rd_ptr].dest;
      WriteData   = mem[rd_ptr].data;
    end
  end

  wb_pending_cam #(.DEPTH(DEPTH)) u_cam_rs (
    .entries (mem),
    .valid   (valid_mask),
    .head    (rd_ptr),
    .addr    (rs),
    .hit_c   (fwd_hit_rs),
    .data_c  (fwd_data_rs)
  );

  wb_pending_cam #(.DEPTH(DEPTH)) u_cam_rt (
    .entries (mem),
    .valid   (valid_mask),
    .head    (rd_ptr),
    .addr    (rt),
    .hit_c   (fwd_hit_rt),
    .data_c  (fwd_data_rt)
  );

endmodule

// File: tb/tb_wb_write_serializer.sv
// Directed bench for wb_write_serializer with a queue-based scoreboard.
module tb_wb_write_serializer;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        Reset;
  logic        wb0_valid, wb1_valid;
  logic [4:0]  wb0_dest, wb1_dest;
  logic [31:0] wb0_data, wb1_data;
  logic        wb_stall;
  logic        RegWrite;
  logic [4:0]  WriteReg_WB;
  logic [31:0] WriteData;
  logic [4:0]  rs, rt;
  logic        fwd_hit_rs, fwd_hit_rt;
  logic [31:0] fwd_data_rs, fwd_data_rt;

  wb_entry_t sb[$];
  int        checks = 0;
  int        errors = 0;
  bit        saw_stall = 1'b0;

  always #5 clk = ~clk;

  wb_write_serializer #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .wb0_valid   (wb0_valid),
    .wb0_dest    (wb0_dest),
    .wb0_data    (wb0_data),
    .wb1_valid   (wb1_valid),
    .wb1_dest    (wb1_dest),
    .wb1_data    (wb1_data),
    .wb_stall    (wb_stall),
    .RegWrite    (RegWrite),
    .WriteReg_WB (WriteReg_WB),
    .WriteData   (WriteData),
    .rs          (rs),
    .rt          (rt),
    .fwd_hit_rs  (fwd_hit_rs),
    .fwd_hit_rt  (fwd_hit_rt),
    .fwd_data_rs (fwd_data_rs),
    .fwd_data_rt (fwd_data_rt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest queued write to addr; r0 never matches.
  function automatic void model_fwd(input logic [4:0] addr, output bit hit, output logic [31:0] data);
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < sb.size(); i++) begin
      if ((addr != 5'd0) && (sb[i].dest == addr)) begin
        hit  = 1'b1;
        data = sb[i].data;
      end
    end
  endfunction

  // One cycle: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic tick(output bit accepted);
    bit          stall_m, hit, e0, e1;
    logic [31:0] d;
    @(negedge clk);
    stall_m = (sb.size() > int'(DEPTH) - 2);
    if (stall_m) saw_stall = 1'b1;
    chk("wb_stall", wb_stall, stall_m);
    if (sb.size() != 0) begin
      chk("RegWrite", RegWrite, 1);
      chk("WriteReg_WB", WriteReg_WB, sb[0].dest);
      chk("WriteData", WriteData, sb[0].data);
    end else begin
      chk("RegWrite_idle", RegWrite, 0);
      chk("WriteReg_WB_idle", WriteReg_WB, 0);
      chk("WriteData_idle", WriteData, 0);
    end
    model_fwd(rs, hit, d);
    chk("fwd_hit_rs", fwd_hit_rs, hit);
    if (hit || sb.size() == 0) chk("fwd_data_rs", fwd_data_rs, d);
    model_fwd(rt, hit, d);
    chk("fwd_hit_rt", fwd_hit_rt, hit);
    if (hit || sb.size() == 0) chk("fwd_data_rt", fwd_data_rt, d);
    accepted = Reset && !stall_m;
    @(posedge clk);
    if (!Reset) begin
      sb.delete();
    end else begin
      if (sb.size() != 0) void'(sb.pop_front());
      if (!stall_m) begin
        e1 = wb1_valid && (wb1_dest != 5'd0);
        e0 = wb0_valid && (wb0_dest != 5'd0) && !(e1 && (wb0_dest == wb1_dest));
        if (e0) sb.push_back('{dest: wb0_dest, data: wb0_data});
        if (e1) sb.push_back('{dest: wb1_dest, data: wb1_data});
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) tick(acc);
  endtask

  // Present both lanes and hold them until accepted (bounded).
  task automatic send(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1);
    bit acc;
    int n;
    wb0_valid = v0; wb0_dest = a0; wb0_data = d0;
    wb1_valid = v1; wb1_dest = a1; wb1_data = d1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      tick(acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed not accepted after %0d cycles expected accepted", n);
    end
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
  endtask

  initial begin
    // Reset hold with live lanes
    Reset = 1'b0;
    wb0_valid = 1'b1; wb0_dest = 5'd3; wb0_data = 32'h0303;
    wb1_valid = 1'b1; wb1_dest = 5'd4; wb1_data = 32'h0404;
    rs = 5'd3; rt = 5'd4;
    idle(2);
    Reset = 1'b1;
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    idle(2);

    // Dual write, distinct destinations
    rs = 5'd5; rt = 5'd6;
    send(1, 5'd5, 32'h11, 1, 5'd6, 32'h22);
    idle(3);

    // Same destination: younger lane wins
    rs = 5'd7; rt = 5'd0;
    send(1, 5'd7, 32'hAAAA, 1, 5'd7, 32'hBBBB);
    idle(2);

    // r0 filtered out
    rs = 5'd0; rt = 5'd9;
    send(1, 5'd0, 32'hFF, 1, 5'd9, 32'h33);
    idle(2);

    // Fill, stall and pointer wrap
    saw_stall = 1'b0;
    for (int p = 0; p < 6; p++) begin
      rs = 5'(2 * p + 1);
      rt = 5'(2 * p);
      send(1, 5'(2 * p + 1), 32'h1000 + 32'(2 * p + 1),
           1, 5'(2 * p + 2), 32'h1000 + 32'(2 * p + 2));
    end
    idle(8);
    chk("fill_stall_seen", saw_stall, 1);

    // Reset while three entries are queued
    rs = 5'd22; rt = 5'd23;
    send(1, 5'd20, 32'h2020, 1, 5'd21, 32'h2121);
    send(1, 5'd22, 32'h2222, 1, 5'd23, 32'h2323);
    Reset = 1'b0;
    idle(1);
    Reset = 1'b1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
